// File: rtl/x_irq_pkg.sv
// x_irq_pkg: shared widths, FSM state encoding and a one-hot helper for the
// x_irq_collect32 event collector and its priority encoder.
package x_irq_pkg;

  localparam int X_IRQ_W   = 32;
  localparam int X_IRQ_IDW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } x_irq_state_e;

  // One-hot vector with only bit idx set.
  function automatic logic [X_IRQ_W-1:0] x_irq_onehot(input logic [X_IRQ_IDW-1:0] idx);
    logic [X_IRQ_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/x_prio_enc32.sv
// x_prio_enc32: combinational lowest-set-bit encoder.
//   vec_i  32-bit input vector
//   idx_o  index of the lowest set bit (0 when vec_i is all zero)
//   any_o  OR-reduction of vec_i
module x_prio_enc32
  import x_irq_pkg::*;
(
  input  logic [X_IRQ_W-1:0]   vec_i,
  output logic [X_IRQ_IDW-1:0] idx_o,
  output logic                 any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = X_IRQ_W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = X_IRQ_IDW'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/x_irq_collect32.sv
// x_irq_collect32: captures 32 event lines into sticky pending flags (masked at
// capture) that feed a downstream OR32, and serialises pending events to a
// consumer over a REQ/ACK handshake carrying the lowest pending index.
//   CLK     clock, rising edge
//   RSTN    synchronous active-low reset
//   EV      event lines (synchronous to CLK)
//   MASK    per-bit capture enable
//   CLR     write-1-to-clear pattern, applied when CLR_EN=1
//   CLR_EN  apply CLR this cycle
//   PEND    sticky pending flags
//   O       OR of PEND, straight from the register
//   REQ     request to consumer, ID valid while high
//   ID      index being presented
//   ACK     consumer accepts ID
module x_irq_collect32
  import x_irq_pkg::*;
#(
  parameter bit                 EDGE = 1'b1,
  parameter logic [X_IRQ_W-1:0] INIT = '0
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [X_IRQ_W-1:0]   EV,
  input  logic [X_IRQ_W-1:0]   MASK,
  input  logic [X_IRQ_W-1:0]   CLR,
  input  logic                 CLR_EN,
  output logic [X_IRQ_W-1:0]   PEND,
  output logic                 O,
  output logic                 REQ,
  output logic [X_IRQ_IDW-1:0] ID,
  input  logic                 ACK
);

  logic [X_IRQ_W-1:0]   pend_q, pend_d;
  logic [X_IRQ_W-1:0]   ev_d_q;
  logic [X_IRQ_W-1:0]   cap, ackclr, clrv;
  logic                 req_q, req_d;
  logic [X_IRQ_IDW-1:0] id_q, id_d;
  x_irq_state_e         state_q, state_d;
  logic [X_IRQ_IDW-1:0] low_idx;
  logic                 any_pend;

  x_prio_enc32 u_enc (
    .vec_i (pend_q),
    .idx_o (low_idx),
    .any_o (any_pend)
  );

  // Pending update: set has priority over clear so an event arriving in the
  // same cycle as its ACK/CLR is not lost.
  always_comb begin
    cap    = EDGE ? (EV & ~ev_d_q) : EV;
    ackclr = '0;
    if (state_q == S_WAIT && ACK) ackclr = x_irq_onehot(id_q);
    clrv   = (CLR_EN ? CLR : '0) | ackclr;
    pend_d = (pend_q & ~clrv) | (cap & MASK);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_pend) begin
          id_d    = low_idx;
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // ACK, or a CLR withdrawing the presented bit, ends the request.
        if (ACK || (CLR_EN && CLR[id_q])) begin
          req_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pend_q  <= INIT;
      ev_d_q  <= '0;
      req_q   <= 1'b0;
      id_q    <= '0;
      state_q <= S_IDLE;
    end else begin
      pend_q  <= pend_d;
      ev_d_q  <= EV;
      req_q   <= req_d;
      id_q    <= id_d;
      state_q <= state_d;
    end
  end

  assign PEND = pend_q;
  assign O    = any_pend;
  assign REQ  = req_q;
  assign ID   = id_q;

endmodule

// File: tb/tb_x_irq_collect32.sv
module tb_x_irq_collect32;

  localparam logic [31:0] M = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RSTN, CLR_EN, ACK, O, REQ;
  logic [31:0] EV, MASK, CLR, PEND;
  logic [4:0]  ID;

  int checks = 0;
  int errors = 0;

  x_irq_collect32 #(.EDGE(1'b1), .INIT(32'h0)) dut (
    .CLK(CLK), .RSTN(RSTN), .EV(EV), .MASK(MASK), .CLR(CLR), .CLR_EN(CLR_EN),
    .PEND(PEND), .O(O), .REQ(REQ), .ID(ID), .ACK(ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rstn;
    logic [31:0] ev;
    logic [31:0] mask;
    logic        clr_en;
    logic [31:0] clr;
    logic        ack;
    logic [31:0] pend;
    logic        req;
    logic        chk_id;
    logic [4:0]  id;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   idq[$];

  function automatic vec_t mk(logic rstn, logic [31:0] ev, logic [31:0] mask,
                              logic clr_en, logic [31:0] clr, logic ack,
                              logic [31:0] pend, logic req, logic chk_id, logic [4:0] id);
    vec_t v;
    v.rstn = rstn; v.ev = ev; v.mask = mask; v.clr_en = clr_en; v.clr = clr;
    v.ack = ack; v.pend = pend; v.req = req; v.chk_id = chk_id; v.id = id;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, push its expectation, and compare after the edge.
  task automatic apply(input vec_t v, input int row);
    vec_t e;
    RSTN = v.rstn; EV = v.ev; MASK = v.mask; CLR_EN = v.clr_en; CLR = v.clr; ACK = v.ack;
    sb.push_back(v);
    @(posedge CLK); #1;
    e = sb.pop_front();
    check($sformatf("row%0d PEND", row), PEND, e.pend);
    check($sformatf("row%0d O", row), {31'd0, O}, {31'd0, |e.pend});
    check($sformatf("row%0d REQ", row), {31'd0, REQ}, {31'd0, e.req});
    if (e.chk_id) check($sformatf("row%0d ID", row), {27'd0, ID}, {27'd0, e.id});
  endtask

  initial begin
    int low_cnt, cyc;
    bit first;

    RSTN = 1'b0; EV = '0; MASK = M; CLR = '0; CLR_EN = 1'b0; ACK = 1'b0;

    //               rstn ev            mask     ce clr      ack pend          req chk id
    // reset with events active, release with EV low
    tbl.push_back(mk(0, M,            M,       0, 0,       0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(0, M,            M,       0, 0,       0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h0,        0, 0, 0));
    // single event on bit 7
    tbl.push_back(mk(1, 32'h80,       M,       0, 0,       0, 32'h80,       0, 0, 0));
    tbl.push_back(mk(1, 32'h80,       M,       0, 0,       0, 32'h80,       1, 1, 7));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h0,        0, 0, 0));
    // masking on bit 3
    tbl.push_back(mk(1, 32'h8,        ~32'h8,  0, 0,       0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0,            ~32'h8,  0, 0,       0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 32'h8,        M,       0, 0,       0, 32'h8,        0, 0, 0));
    tbl.push_back(mk(1, 0,            ~32'h8,  0, 0,       0, 32'h8,        1, 1, 3));
    tbl.push_back(mk(1, 0,            ~32'h8,  0, 0,       0, 32'h8,        1, 1, 3));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h0,        0, 0, 0));
    // ordering 0,4,31 with ACK held (ACK in IDLE ignored)
    tbl.push_back(mk(1, 32'h8000_0011, M,      0, 0,       0, 32'h8000_0011, 0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h8000_0011, 1, 1, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h8000_0010, 0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h8000_0010, 0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h8000_0010, 1, 1, 4));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h8000_0000, 0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h8000_0000, 0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h8000_0000, 1, 1, 31));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h0,        0, 0, 0));
    // collision: ACK and new capture on bit 5, then withdraw via CLR
    tbl.push_back(mk(1, 32'h20,       M,       0, 0,       0, 32'h20,       0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h20,       1, 1, 5));
    tbl.push_back(mk(1, 32'h20,       M,       0, 0,       1, 32'h20,       0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h20,       0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h20,       1, 1, 5));
    tbl.push_back(mk(1, 0,            M,       1, 32'h20,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h0,        0, 0, 0));
    // lower index arriving during WAIT does not pre-empt
    tbl.push_back(mk(1, 32'h100,      M,       0, 0,       0, 32'h100,      0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h100,      1, 1, 8));
    tbl.push_back(mk(1, 32'h2,        M,       0, 0,       0, 32'h102,      1, 1, 8));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h2,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h2,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h2,        1, 1, 1));
    // reset mid-handshake with ID=2 and ACK high
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 32'h4,        M,       0, 0,       0, 32'h4,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h4,        1, 1, 2));
    tbl.push_back(mk(0, 0,            M,       0, 0,       1, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0,            M,       0, 0,       1, 32'h0,        0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // All 32 bits pending, ACK held: expect IDs 0..31 with >=2 low cycles between.
    RSTN = 1'b1; EV = M; MASK = M; CLR_EN = 1'b0; CLR = '0; ACK = 1'b0;
    for (int i = 0; i < 32; i++) idq.push_back(i);
    @(posedge CLK); #1;
    check("all32 PEND", PEND, M);
    EV = '0; ACK = 1'b1;
    low_cnt = 0; first = 1'b1; cyc = 0;
    while (idq.size() > 0 && cyc < 300) begin
      @(posedge CLK); #1;
      cyc++;
      if (REQ) begin
        check("all32 ID", {27'd0, ID}, idq.pop_front());
        if (!first) check("all32 gap>=2", {31'd0, low_cnt >= 2}, 32'd1);
        first = 1'b0;
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
    end
    check("all32 served", idq.size(), 0);
    @(posedge CLK); #1;
    ACK = 1'b0;
    check("all32 PEND empty", PEND, 32'h0);
    check("all32 O low", {31'd0, O}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
